// File: rtl/change_dispenser_if.sv
// Request, hopper handshake and status signals of the change dispenser.
// The dispenser takes the slave side and its environment takes the master side.
interface change_dispenser_if #(
    parameter int AMT_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [AMT_W-1:0] change_amt;
    logic [3:0]       hopper_empty;
    logic             coin_valid;
    logic             coin_ready;
    logic [1:0]       coin_sel;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remaining;

    modport master (
        output req_valid, change_amt, hopper_empty, coin_ready,
        input  req_ready, coin_valid, coin_sel, done, short, remaining
    );

    modport slave (
        input  req_valid, change_amt, hopper_empty, coin_ready,
        output req_ready, coin_valid, coin_sel, done, short, remaining
    );
endinterface

// File: rtl/change_dispenser.sv
// Pays out a rupee amount with Rs10/Rs5/Rs2/Rs1 coins, largest usable coin first.
// Coins go out over a valid/ready handshake, and a one-cycle done or short pulse ends each request.
module change_dispenser #(
    parameter int AMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    change_dispenser_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        ISSUE  = 3'd2,
        DONE   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [1:0]       coin_sel_r;
    logic [1:0]       coin_sel_s;
    logic [AMT_W-1:0] remaining_r;
    logic [AMT_W-1:0] remaining_s;
    logic [2:0]       pick_s;
    logic             coin_valid_r;
    logic             done_r;
    logic             short_r;
    logic             req_ready_r;

    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'b00:   coin_value = AMT_W'(1);
            2'b01:   coin_value = AMT_W'(2);
            2'b10:   coin_value = AMT_W'(5);
            2'b11:   coin_value = AMT_W'(10);
            default: coin_value = AMT_W'(0);
        endcase
    endfunction

    // Returns {found, sel} for the largest non-empty denomination not exceeding amt.
    // Because the chosen value never exceeds amt, the later subtraction cannot underflow.
    function automatic logic [2:0] pick_coin(input logic [AMT_W-1:0] amt,
                                             input logic [3:0]       empty);
        if (!empty[3] && (coin_value(2'b11) <= amt)) begin
            pick_coin = {1'b1, 2'b11};
        end else if (!empty[2] && (coin_value(2'b10) <= amt)) begin
            pick_coin = {1'b1, 2'b10};
        end else if (!empty[1] && (coin_value(2'b01) <= amt)) begin
            pick_coin = {1'b1, 2'b01};
        end else if (!empty[0] && (coin_value(2'b00) <= amt)) begin
            pick_coin = {1'b1, 2'b00};
        end else begin
            pick_coin = 3'b000;
        end
    endfunction

    // Next-state logic, plus the next values of coin_sel and remaining
    always_comb begin
        state_s     = state_r;
        coin_sel_s  = coin_sel_r;
        remaining_s = remaining_r;
        pick_s      = pick_coin(remaining_r, bus.hopper_empty);
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    state_s     = SELECT;
                    remaining_s = bus.change_amt;
                end else begin
                    state_s = IDLE;
                end
            end
            SELECT: begin
                if (remaining_r == {AMT_W{1'b0}}) begin
                    state_s = DONE;
                end else if (pick_s[2]) begin
                    state_s    = ISSUE;
                    coin_sel_s = pick_s[1:0];
                end else begin
                    state_s = FAULT;
                end
            end
            ISSUE: begin
                if (bus.coin_ready) begin
                    state_s     = SELECT;
                    remaining_s = remaining_r - coin_value(coin_sel_r);
                end else begin
                    state_s = ISSUE;
                end
            end
            DONE:    state_s = IDLE;
            FAULT:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register; the outputs are decoded from the next state, so each one comes straight from a flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            coin_sel_r   <= 2'b00;
            remaining_r  <= {AMT_W{1'b0}};
            coin_valid_r <= 1'b0;
            done_r       <= 1'b0;
            short_r      <= 1'b0;
            req_ready_r  <= 1'b1;
        end else begin
            state_r      <= state_s;
            coin_sel_r   <= coin_sel_s;
            remaining_r  <= remaining_s;
            coin_valid_r <= (state_s == ISSUE);
            done_r       <= (state_s == DONE);
            short_r      <= (state_s == FAULT);
            req_ready_r  <= (state_s == IDLE);
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.coin_valid = coin_valid_r;
    assign bus.coin_sel   = coin_sel_r;
    assign bus.done       = done_r;
    assign bus.short      = short_r;
    assign bus.remaining  = remaining_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a vector table, hand-written reset sequences,
// and random requests checked against a greedy coin-change reference model.
module tb_change_dispenser;

    localparam int AMT_W  = 5;
    localparam int BUDGET = 400;

    typedef struct {
        logic [AMT_W-1:0] amt;
        logic [3:0]       empty;
        int               stall;
        int               n;
        logic [15:0]      seq;
        bit               exp_done;
        int               exp_rem;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    change_dispenser_if #(.AMT_W(AMT_W)) bus();
    change_dispenser #(.AMT_W(AMT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         n_checks = 0;
    int         n_fail   = 0;
    int         vals[4]  = '{1, 2, 5, 10};
    logic [1:0] obs_q[$];
    logic [1:0] exp_q[$];
    bit         got_done;
    bit         got_short;
    int         end_cyc;
    int         rem_end;
    vec_t       vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Greedy payout: repeatedly take the largest stocked coin that still fits.
    function automatic void model(input int amt, input logic [3:0] empty,
                                  output int rem, output bit shrt);
        int pick;
        rem  = amt;
        shrt = 1'b0;
        exp_q.delete();
        while (rem > 0) begin
            pick = -1;
            for (int d = 3; d >= 0; d--)
                if (pick < 0 && !empty[d] && vals[d] <= rem) pick = d;
            if (pick < 0) begin
                shrt = 1'b1;
                break;
            end
            exp_q.push_back(2'(pick));
            rem -= vals[pick];
        end
    endfunction

    // Called at a negedge with the block idle. Presents one request, drives the hopper
    // (stall = ready-low cycles per coin), scrambles ignored inputs and records the coins paid.
    task automatic run_txn(input logic [AMT_W-1:0] amt, input logic [3:0] empty, input int stall);
        int         stall_left;
        int         rem_track;
        logic [1:0] held_sel;
        bit         new_coin;
        bit         prev_hs;
        bit         finished;
        obs_q.delete();
        got_done  = 1'b0;
        got_short = 1'b0;
        end_cyc   = 0;
        rem_end   = 0;
        finished  = 1'b0;
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.change_amt   = amt;
        bus.hopper_empty = empty;
        bus.coin_ready   = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        new_coin   = 1'b1;
        prev_hs    = 1'b0;
        rem_track  = int'(amt);
        stall_left = 0;
        held_sel   = 2'b00;
        for (int c = 1; c <= BUDGET && !finished; c++) begin
            if (prev_hs) check("coin_gap", 32'(bus.coin_valid), 32'd0);
            prev_hs = 1'b0;
            if (bus.done || bus.short) begin
                check("done_short_excl", 32'(bus.done & bus.short), 32'd0);
                got_done       = bus.done;
                got_short      = bus.short;
                end_cyc        = c;
                rem_end        = int'(bus.remaining);
                finished       = 1'b1;
                bus.req_valid  = 1'b0;
                bus.coin_ready = 1'b0;
            end else begin
                check("req_ready_busy", 32'(bus.req_ready), 32'd0);
                if (bus.coin_valid) begin
                    if (new_coin) begin
                        if (obs_q.size() == 0) check("first_coin_latency", 32'(c), 32'd2);
                        new_coin   = 1'b0;
                        stall_left = stall;
                        held_sel   = bus.coin_sel;
                    end else begin
                        check("coin_sel_hold", 32'(bus.coin_sel), 32'(held_sel));
                    end
                    check("remaining_in_issue", 32'(bus.remaining), 32'(rem_track));
                    bus.hopper_empty = 4'($urandom);
                    if (stall_left > 0) begin
                        bus.coin_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.coin_ready = 1'b1;
                        obs_q.push_back(bus.coin_sel);
                        rem_track -= vals[bus.coin_sel];
                        new_coin = 1'b1;
                        prev_hs  = 1'b1;
                    end
                end else begin
                    bus.coin_ready   = 1'($urandom);
                    bus.hopper_empty = empty;
                end
                bus.req_valid  = 1'($urandom);
                bus.change_amt = AMT_W'($urandom);
                @(negedge clk);
            end
        end
        if (!finished) begin
            check("timeout", 32'd1, 32'd0);
            bus.req_valid  = 1'b0;
            bus.coin_ready = 1'b0;
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
        end else begin
            @(negedge clk);
            check("pulse_one_cycle", 32'({bus.done, bus.short}), 32'd0);
            check("req_ready_back", 32'(bus.req_ready), 32'd1);
            check("remaining_hold", 32'(bus.remaining), 32'(rem_track));
        end
    endtask

    task automatic verify(input bit e_done, input int e_rem, input int stall);
        check("coin_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check("coin_sel_seq", 32'(obs_q[i]), 32'(exp_q[i]));
        check("done_flag", 32'(got_done), 32'(e_done));
        check("short_flag", 32'(got_short), 32'(!e_done));
        check("remaining_end", 32'(rem_end), 32'(e_rem));
        check("end_latency", 32'(end_cyc), 32'(2 + exp_q.size() * (2 + stall)));
    endtask

    initial begin
        int  m_rem;
        bit  m_short;
        int  r_amt;
        int  r_stall;
        logic [3:0] r_empty;

        // amt, empty, stall, n, seq (first coin in [1:0]), done, rem
        vecs[0] = '{5'd18, 4'b0000, 0, 4, 16'h001B, 1'b1, 0};
        vecs[1] = '{5'd0,  4'b0000, 0, 0, 16'h0000, 1'b1, 0};
        vecs[2] = '{5'd7,  4'b0100, 0, 4, 16'h0015, 1'b1, 0};
        vecs[3] = '{5'd3,  4'b0001, 0, 1, 16'h0001, 1'b0, 1};
        vecs[4] = '{5'd10, 4'b0000, 5, 1, 16'h0003, 1'b1, 0};
        vecs[5] = '{5'd5,  4'b1111, 0, 0, 16'h0000, 1'b0, 5};
        vecs[6] = '{5'd31, 4'b0000, 1, 4, 16'h003F, 1'b1, 0};
        vecs[7] = '{5'd9,  4'b1000, 2, 3, 16'h0016, 1'b1, 0};

        bus.req_valid    = 1'b0;
        bus.change_amt   = '0;
        bus.hopper_empty = 4'b0000;
        bus.coin_ready   = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_coin_valid", 32'(bus.coin_valid), 32'd0);
        check("rst_coin_sel", 32'(bus.coin_sel), 32'd0);
        check("rst_remaining", 32'(bus.remaining), 32'd0);
        check("rst_done_short", 32'({bus.done, bus.short}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[k]) begin
            exp_q.delete();
            for (int i = 0; i < vecs[k].n; i++) exp_q.push_back(vecs[k].seq[2*i +: 2]);
            run_txn(vecs[k].amt, vecs[k].empty, vecs[k].stall);
            verify(vecs[k].exp_done, vecs[k].exp_rem, vecs[k].stall);
        end

        // Reset while a coin is on offer: everything drops without a clock edge
        bus.req_valid    = 1'b1;
        bus.change_amt   = 5'd18;
        bus.hopper_empty = 4'b0000;
        bus.coin_ready   = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_coin_valid", 32'(bus.coin_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_coin_valid", 32'(bus.coin_valid), 32'd0);
        check("async_rst_remaining", 32'(bus.remaining), 32'd0);
        check("async_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("async_rst_coin_sel", 32'(bus.coin_sel), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model(13, 4'b0000, m_rem, m_short);
        run_txn(5'd13, 4'b0000, 1);
        verify(!m_short, m_rem, 1);

        for (int t = 0; t < 40; t++) begin
            r_amt   = $urandom_range(0, 31);
            r_empty = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom & $urandom);
            r_stall = $urandom_range(0, 2);
            model(r_amt, r_empty, m_rem, m_short);
            run_txn(AMT_W'(r_amt), r_empty, r_stall);
            verify(!m_short, m_rem, r_stall);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The module SHALL have parameter AMT_W, default 5: width of the change amount in rupees.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port req_valid, input, 1 bit: a change request is present.
REQ-005 The module SHALL have port req_ready, output, 1 bit: block idle, can accept a request.
REQ-006 The module SHALL have port change_amt, input, AMT_W bits: rupees owed, unsigned.
REQ-007 The module SHALL have port hopper_empty, input, 4 bits: per-denomination empty flag; bit0=Rs1, bit1=Rs2, bit2=Rs5, bit3=Rs10.
REQ-008 The module SHALL have port coin_valid, output, 1 bit: a coin is offered to the hopper.
REQ-009 The module SHALL have port coin_ready, input, 1 bit: hopper ejects the offered coin.
REQ-010 The module SHALL have port coin_sel, output, 2 bits: coin denomination, encoded 00=Rs1, 01=Rs2, 10=Rs5, 11=Rs10.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse, change fully paid.
REQ-012 The module SHALL have port short, output, 1 bit: one-cycle pulse, change cannot be completed.
REQ-013 The module SHALL have port remaining, output, AMT_W bits: rupees still owed.

Function
REQ-014 The FSM SHALL have states IDLE, SELECT, ISSUE, DONE, FAULT.
REQ-015 req_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, on req_valid=1, the block SHALL load remaining<=change_amt and go to SELECT on the same edge.
REQ-017 In SELECT with remaining=0, the next state SHALL be DONE.
REQ-018 In SELECT with remaining>0, the block SHALL sample hopper_empty and pick the largest denomination that is <= remaining and not empty.
REQ-019 When SELECT finds an eligible denomination, it SHALL register coin_sel and go to ISSUE.
REQ-020 When SELECT finds no eligible denomination, it SHALL go to FAULT.
REQ-021 In ISSUE, coin_valid SHALL be 1.
REQ-022 In ISSUE, coin_sel SHALL be held stable until the handshake.
REQ-023 In ISSUE, changes on hopper_empty SHALL be ignored.
REQ-024 A handshake (coin_valid=1 and coin_ready=1) SHALL subtract the coin value from remaining on that edge.
REQ-025 After a handshake, the next state SHALL be SELECT, so coin_valid is low for at least one cycle between coins.
REQ-026 With coin_ready=0, the FSM SHALL stay in ISSUE indefinitely and remaining SHALL NOT change.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-028 FAULT SHALL assert short=1 for exactly one cycle, then return to IDLE.
REQ-029 After FAULT, remaining SHALL keep the unpaid amount until the next accepted request.
REQ-030 Subtraction SHALL never underflow, because the selected coin value is always <= remaining.
REQ-031 A request with change_amt=0 SHALL produce done one cycle after SELECT, with no coin_valid.
REQ-032 req_valid SHALL be ignored outside IDLE.
REQ-033 coin_ready SHALL be ignored outside ISSUE.
REQ-034 done and short SHALL never be 1 in the same cycle.
REQ-035 The latency from request acceptance to the first coin_valid SHALL be 2 edges (accept -> SELECT -> ISSUE).
REQ-036 Each further coin SHALL add 2 edges plus any coin_ready stall.

Reset
REQ-037 rst=0 SHALL force, immediately and asynchronously, state=IDLE, coin_valid=0, coin_sel=00, done=0, short=0, remaining=0, req_ready=1.
REQ-038 A reset during ISSUE SHALL drop coin_valid with no handshake counted.
REQ-039 The request in progress at reset SHALL be discarded.
REQ-040 After rst returns to 1, the block SHALL be able to accept a request on the first rising edge.

Verification
REQ-041 Bench SHALL cover: change_amt=18, hopper_empty=0000, coin_ready=1 -> coin_sel sequence 11,10,01,00; then done pulse; remaining=0.
REQ-042 Bench SHALL cover: change_amt=0 -> no coin_valid; done=1 exactly 2 edges after acceptance.
REQ-043 Bench SHALL cover: change_amt=7, hopper_empty=0100 -> coins Rs2,Rs2,Rs2,Rs1; then done.
REQ-044 Bench SHALL cover: change_amt=3, hopper_empty=0001 -> one Rs2 coin; then short pulse; remaining=1; done stays 0.
REQ-045 Bench SHALL cover: change_amt=10 with coin_ready held 0 for 5 cycles -> coin_valid=1 and coin_sel=11 stable throughout; remaining=10 until the handshake, then done.
REQ-046 Bench SHALL cover: rst pulsed low during ISSUE -> coin_valid=0 and remaining=0 without waiting for a clock; a new request after reset is served normally.
